// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: single-outstanding instruction fetch request controller that drops stale responses
// Ports: cpu_clk/cpu_rstn clock and async active-low reset; boot_addr pc value at reset;
//  next_pc fetch address from IF; instr_read_data_valid/instr_read_data/instr_bus_err delivery to IF;
//  mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata/mem_err memory read port;
//  drop_cnt saturating count of dropped stale responses.
module imem_fetch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] ERR_INSTR = 'h13,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   instr_bus_err,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   mem_err,
  output logic [CNT_WIDTH-1:0]   drop_cnt
);
  typedef enum logic {REQ, WAIT} state_t;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, pc_q;
  logic rst_done, accept, hit, drop;
  assign mem_addr = next_pc & WORD_MASK;
  // In WAIT a new request is only raised in the response cycle, keeping one request in flight.
  always_comb begin
    mem_req = rst_done && (state == REQ || mem_rvalid);
    accept = mem_req && mem_gnt;
    hit = rst_done && state == WAIT && mem_rvalid && addr_q == (pc_q & WORD_MASK);
    drop = rst_done && state == WAIT && mem_rvalid && !hit;
    state_nxt = state == REQ ? (accept ? WAIT : REQ) : (mem_rvalid && !accept ? REQ : WAIT);
    instr_read_data_valid = hit;
    instr_bus_err = hit && mem_err;
    instr_read_data = mem_err ? ERR_INSTR : mem_rdata;
  end
  always_ff @(posedge cpu_clk or negedge cpu_rstn)
    if (!cpu_rstn) begin
      state <= REQ;
      addr_q <= '0;
      pc_q <= boot_addr;
      drop_cnt <= '0;
      rst_done <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q <= next_pc;
      rst_done <= 1'b1;
      if (accept) addr_q <= mem_addr;
      if (drop && ~&drop_cnt) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed and randomized checks of imem_fetch_ctrl against a transaction-level model
module tb_imem_fetch_ctrl;
  logic cpu_clk = 0, cpu_rstn = 0;
  logic [31:0] boot_addr = 0, next_pc = 0, instr_read_data, mem_addr, mem_rdata = 0;
  logic instr_read_data_valid, instr_bus_err, mem_req, mem_gnt = 0, mem_rvalid = 0, mem_err = 0;
  logic [3:0] drop_cnt;
  int vectors = 0, miscompares = 0;
  bit m_rst_done = 0, m_out = 0;
  logic [31:0] m_pc = 0, m_addr = 0;
  int m_lat = 0, m_drops = 0;
  logic o_req, o_valid, o_err;
  logic [31:0] o_addr, o_data;
  int vcount;

  imem_fetch_ctrl #(.CNT_WIDTH(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .boot_addr(boot_addr), .next_pc(next_pc),
    .instr_read_data_valid(instr_read_data_valid), .instr_read_data(instr_read_data),
    .instr_bus_err(instr_bus_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err), .drop_cnt(drop_cnt));

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // gm/em: 0 or 1 forced, 2 random; lat: cycles after the grant cycle until rvalid minus one, -1 random;
  // pm: 0 IF advances on delivery else holds, 1 next_pc=tgt, 2 like 0 with random redirects.
  task automatic step(input int gm, input int lat, input int pm, input logic [31:0] tgt, input int em);
    logic rv, g, e, ereq, hit;
    logic [31:0] npc, rd, ra;
    rv = m_out && m_lat == 0;
    g = gm == 2 ? ($urandom_range(0, 3) != 0) : (gm == 1);
    e = em == 2 ? ($urandom_range(0, 7) == 0) : (em == 1);
    rd = memword(m_addr);
    mem_rvalid = rv;
    mem_gnt = g;
    mem_rdata = rv ? rd : $urandom;
    mem_err = rv ? e : ($urandom_range(0, 1) == 1);
    ereq = m_rst_done && (!m_out || rv);
    hit = m_rst_done && rv && m_addr == (m_pc & ~32'd3);
    ra = $urandom_range(0, 63);
    npc = pm == 1 ? tgt : (pm == 2 && $urandom_range(0, 3) == 0) ? ra : hit ? m_pc + 4 : m_pc;
    next_pc = npc;
    #1;
    chk("mem_req", mem_req, ereq);
    if (ereq) chk("mem_addr", mem_addr, npc & ~32'd3);
    chk("valid", instr_read_data_valid, hit);
    chk("bus_err", instr_bus_err, hit && e);
    if (hit) chk("data", instr_read_data, e ? 32'h13 : rd);
    chk("drop_cnt", drop_cnt, m_drops);
    o_req = mem_req; o_addr = mem_addr; o_valid = instr_read_data_valid;
    o_err = instr_bus_err; o_data = instr_read_data;
    @(posedge cpu_clk);
    if (rv && !hit && m_drops != 15) m_drops++;
    if (ereq && g) begin
      m_out = 1;
      m_addr = npc & ~32'd3;
      m_lat = lat < 0 ? $urandom_range(0, 2) : lat;
    end else if (rv) m_out = 0;
    else if (m_out) m_lat--;
    m_pc = npc;
    m_rst_done = 1;
    #1;
  endtask

  initial begin
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_valid", instr_read_data_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    repeat (2) @(posedge cpu_clk);
    #1 cpu_rstn = 1;
    // 1: zero-wait memory streams 0x0, 0x4, 0x8
    step(1, 0, 0, 0, 0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      vcount += int'(o_valid);
    end
    chk("t1_valid_run", vcount, 3);
    step(0, 0, 0, 0, 0);
    // 2: latency 3 with pc held at 0x100
    step(0, 0, 1, 32'h100, 0);
    step(1, 2, 1, 32'h100, 0);
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h100, 0);
      vcount += int'(o_valid);
    end
    chk("t2_valid_once", vcount, 1);
    // 3: redirect to 0x200 while 0x100 in flight
    step(1, 1, 1, 32'h100, 0);
    step(0, 0, 1, 32'h200, 0);
    step(1, 0, 1, 32'h200, 0);
    chk("t3_drop_valid", o_valid, 0);
    chk("t3_redirect_addr", o_addr, 32'h200);
    step(0, 0, 1, 32'h200, 0);
    chk("t3_hit", o_valid, 1);
    chk("t3_drop_cnt", drop_cnt, 1);
    // 4: no grant while the address walks 0x40 -> 0x80
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'h40 + 32'h10 * i, 0);
    step(1, 0, 1, 32'h80, 0);
    step(0, 0, 1, 32'h80, 0);
    chk("t4_hit", o_valid, 1);
    chk("t4_no_drop", drop_cnt, 1);
    // 5: bus error substitutes NOP
    step(1, 0, 1, 32'h80, 0);
    step(0, 0, 1, 32'h80, 1);
    chk("t5_valid", o_valid, 1);
    chk("t5_data", o_data, 32'h13);
    chk("t5_err", o_err, 1);
    // 6: reset while waiting
    step(1, 2, 1, 32'h300, 0);
    step(0, 0, 1, 32'h300, 0);
    boot_addr = 32'h8000_0000;
    mem_rvalid = 1;
    mem_gnt = 1;
    cpu_rstn = 0;
    #1;
    chk("t6_req_in_rst", mem_req, 0);
    chk("t6_valid_in_rst", instr_read_data_valid, 0);
    chk("t6_drop_in_rst", drop_cnt, 0);
    repeat (2) @(posedge cpu_clk);
    #1 cpu_rstn = 1;
    m_rst_done = 0; m_out = 0; m_pc = boot_addr; m_drops = 0;
    step(1, 0, 1, 32'h8000_0000, 0);
    step(1, 0, 1, 32'h8000_0000, 0);
    chk("t6_first_req", o_req, 1);
    chk("t6_first_addr", o_addr, 32'h8000_0000);
    step(0, 0, 1, 32'h8000_0000, 0);
    chk("t6_boot_hit", o_valid, 1);
    // randomized traffic, redirects and errors; drop counter saturates
    for (int i = 0; i < 600; i++) step(2, -1, 2, 0, 2);
    chk("sat_drop_cnt", drop_cnt, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
